correlator_scheduler: RTL and testbench

Integration sequencer and readout engine for the CORRELATOR array. It drives the correlator's `enable` and `reset` inputs to run fixed-length integration windows. At the end of each window it snapshots the full `pulses` vector into a shadow register and streams the snapshot out one lag bin per beat over a valid/ready interface. It sits between the host-facing control/readout logic and the correlator datapath.

---
 rtl/corr_sched_pkg.sv | 21 ++
 rtl/corr_frame_drain.sv | 136 +++++++++++++
 rtl/correlator_scheduler.sv | 122 ++++++++++++
 tb/tb_correlator_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_sched_pkg.sv
// rtl/corr_sched_pkg.sv - shared types and constants for the correlator scheduler
package corr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_INTEGRATE,
        ST_SNAPSHOT
    } ctrl_state_e;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_HEADER,
        DR_BINS
    } drain_state_e;

    localparam int              IDX_W     = 16;
    localparam logic [15:0]     HDR_MAGIC = 16'hC0DE;
    localparam logic [IDX_W-1:0] HDR_INDEX = 16'hFFFF;

endpackage

// File: rtl/corr_frame_drain.sv
// rtl/corr_frame_drain.sv - shadow register and valid/ready readout drain; optional header beat via CORR_SCHED_HEADER_EN
import corr_sched_pkg::*;

module corr_frame_drain #(
    parameter int NUM_BINS = 8,
    parameter int DW       = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   snap,
    input  logic                   clr_stats,
    input  logic [NUM_BINS*DW-1:0] pulses,
    output logic [DW-1:0]          m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic [IDX_W-1:0]       m_index,
    output logic                   active,
    output logic                   overrun,
    output logic [15:0]            dropped
);

    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NUM_BINS - 1);

    drain_state_e           dstate_q, dstate_d;
    logic [NUM_BINS*DW-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]       bin_q, bin_d;
    logic                   overrun_q, overrun_d;
    logic [15:0]            dropped_q, dropped_d;
    logic                   capture;
    logic                   fire;
    logic [DW-1:0]          hdr_data;

    assign m_valid = (dstate_q != DR_IDLE);
    assign fire    = m_valid && m_ready;
    // A snapshot is only taken when the previous frame has fully left.
    assign capture = snap && (dstate_q == DR_IDLE);

`ifdef CORR_SCHED_HEADER_EN
    localparam drain_state_e FIRST_BEAT = DR_HEADER;

    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   hdr_id_q, hdr_id_d;
    logic [DW+31:0] hdr_ext;

    // Frame numbering: the header carries the count as it was before this capture.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        hdr_id_d    = hdr_id_q;
        if (clr_stats) begin
            frame_cnt_d = '0;
        end else if (capture) begin
            hdr_id_d    = frame_cnt_q;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Frame numbering registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            hdr_id_q    <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            hdr_id_q    <= hdr_id_d;
        end
    end

    assign hdr_ext  = {{DW{1'b0}}, HDR_MAGIC, hdr_id_q};
    assign hdr_data = hdr_ext[DW-1:0];
`else
    localparam drain_state_e FIRST_BEAT = DR_BINS;

    assign hdr_data = '0;
`endif

    // Beat sequencing, shadow capture and dropped-frame accounting.
    always_comb begin
        dstate_d  = dstate_q;
        shadow_d  = shadow_q;
        bin_d     = bin_q;
        overrun_d = overrun_q;
        dropped_d = dropped_q;
        case (dstate_q)
            DR_HEADER: begin
                if (fire) dstate_d = DR_BINS;
            end
            DR_BINS: begin
                if (fire) begin
                    // Shift so the next bin always sits in the low slice.
                    shadow_d = shadow_q >> DW;
                    if (bin_q == LAST_BIN) dstate_d = DR_IDLE;
                    else                   bin_d    = bin_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
        if (clr_stats) begin
            overrun_d = 1'b0;
            dropped_d = '0;
        end
        if (capture) begin
            shadow_d = pulses;
            bin_d    = '0;
            dstate_d = FIRST_BEAT;
        end else if (snap) begin
            overrun_d = 1'b1;
            if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
        end
    end

    // Drain state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate_q  <= DR_IDLE;
            shadow_q  <= '0;
            bin_q     <= '0;
            overrun_q <= 1'b0;
            dropped_q <= '0;
        end else begin
            dstate_q  <= dstate_d;
            shadow_q  <= shadow_d;
            bin_q     <= bin_d;
            overrun_q <= overrun_d;
            dropped_q <= dropped_d;
        end
    end

    assign m_data  = (dstate_q == DR_HEADER) ? hdr_data : shadow_q[DW-1:0];
    assign m_index = (dstate_q == DR_HEADER) ? HDR_INDEX : bin_q;
    assign m_last  = (dstate_q == DR_BINS) && (bin_q == LAST_BIN);
    assign active  = m_valid;
    assign overrun = overrun_q;
    assign dropped = dropped_q;

endmodule

// File: rtl/correlator_scheduler.sv
// rtl/correlator_scheduler.sv - integration sequencer and readout top; optional header beat via CORR_SCHED_HEADER_EN
import corr_sched_pkg::*;

module correlator_scheduler #(
    parameter int NUM_BASELINES = 8,
    parameter int LAGS          = 1,
    parameter int RESOLUTION    = 24,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      stop,
    input  logic                                      continuous,
    input  logic [CNT_WIDTH-1:0]                      integ_cycles,
    input  logic [NUM_BASELINES*LAGS*RESOLUTION*2-1:0] pulses,
    output logic                                      corr_enable,
    output logic                                      corr_clear,
    output logic [2*RESOLUTION-1:0]                   m_data,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic                                      m_last,
    output logic [15:0]                               m_index,
    output logic                                      busy,
    output logic                                      overrun,
    output logic [15:0]                               dropped
);

    ctrl_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] len_m1_q, len_m1_d;
    logic                 cont_q, cont_d;
    logic                 snap;
    logic                 clr_stats;
    logic                 drain_active;

    // Control FSM: window sequencing and correlator enable/clear.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_m1_d    = len_m1_q;
        cont_d      = cont_q;
        corr_enable = 1'b0;
        corr_clear  = 1'b0;
        snap        = 1'b0;
        clr_stats   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A zero-length window behaves as a single-cycle window.
                    len_m1_d  = (integ_cycles == '0) ? '0 : integ_cycles - CNT_WIDTH'(1);
                    cont_d    = continuous;
                    clr_stats = 1'b1;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                corr_clear = 1'b1;
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = len_m1_q;
                    state_d = ST_INTEGRATE;
                end
            end
            ST_INTEGRATE: begin
                corr_enable = 1'b1;
                if (stop)               state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_SNAPSHOT;
                else                    cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            ST_SNAPSHOT: begin
                // Enable low here clears the correlator on the same edge the shadow captures.
                snap = 1'b1;
                if (cont_q) begin
                    cnt_d   = len_m1_q;
                    state_d = ST_INTEGRATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, window counter and latched configuration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            len_m1_q <= '0;
            cont_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_m1_q <= len_m1_d;
            cont_q   <= cont_d;
        end
    end

    corr_frame_drain #(
        .NUM_BINS (NUM_BASELINES * LAGS),
        .DW       (2 * RESOLUTION)
    ) u_drain (
        .clk       (clk),
        .rst_n     (reset),
        .snap      (snap),
        .clr_stats (clr_stats),
        .pulses    (pulses),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .m_index   (m_index),
        .active    (drain_active),
        .overrun   (overrun),
        .dropped   (dropped)
    );

    assign busy = (state_q != ST_IDLE) || drain_active;

endmodule

// File: tb/tb_correlator_scheduler.sv
// tb/tb_correlator_scheduler.sv - self-checking bench for correlator_scheduler
module tb_correlator_scheduler;

    localparam int NB    = 2;
    localparam int LG    = 2;
    localparam int RES   = 24;
    localparam int CW    = 32;
    localparam int NBINS = NB * LG;
    localparam int DW    = 2 * RES;

    typedef struct packed {
        logic [15:0]   idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              continuous = 1'b0;
    logic              m_ready = 1'b0;
    logic [CW-1:0]     integ_cycles = '0;
    logic [NBINS*DW-1:0] pulses;
    logic              corr_enable, corr_clear, m_valid, m_last, busy, overrun;
    logic [DW-1:0]     m_data;
    logic [15:0]       m_index, dropped;

    int n_assert = 0;
    int n_fail   = 0;

    logic [RES-1:0] acc_r [NBINS];
    logic [RES-1:0] acc_i [NBINS];
    logic [RES-1:0] inc_r [NBINS];
    logic [RES-1:0] inc_i [NBINS];

    beat_t got[$];
    beat_t exp_q[$];
    int    exp_fc = 0;
    int    valid_cycles = 0;
    int    stall_bad = 0;
    logic  stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic [15:0]   stall_idx = '0;

    correlator_scheduler #(
        .NUM_BASELINES (NB),
        .LAGS          (LG),
        .RESOLUTION    (RES),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .integ_cycles (integ_cycles),
        .pulses       (pulses),
        .corr_enable  (corr_enable),
        .corr_clear   (corr_clear),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .m_index      (m_index),
        .busy         (busy),
        .overrun      (overrun),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    // Correlator stand-in: accumulate while enabled, clear otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < NBINS; k++) begin
            if (corr_enable) begin
                acc_r[k] <= acc_r[k] + inc_r[k];
                acc_i[k] <= acc_i[k] + inc_i[k];
            end else begin
                acc_r[k] <= '0;
                acc_i[k] <= '0;
            end
        end
    end

    always_comb begin
        pulses = '0;
        for (int k = 0; k < NBINS; k++) begin
            pulses[k*DW +: RES]       = acc_r[k];
            pulses[k*DW + RES +: RES] = acc_i[k];
        end
    end

    // Stream monitor: records accepted beats and flags any change during a stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (m_valid) valid_cycles++;
            if (stall_prev && (!m_valid || m_data !== stall_data || m_index !== stall_idx))
                stall_bad++;
            if (m_valid && m_ready) got.push_back('{m_index, m_data, m_last});
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_idx  = m_index;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_incs();
        for (int k = 0; k < NBINS; k++) begin
            inc_r[k] = RES'($urandom);
            inc_i[k] = RES'($urandom);
        end
    endtask

    // Expected frame: each bin holds N times its per-cycle increment.
    task automatic add_frame(input int n);
        int nn;
        logic [RES-1:0] r, im;
        logic [DW+31:0] h;
        nn = (n == 0) ? 1 : n;
        h  = {{DW{1'b0}}, 16'hC0DE, 16'(exp_fc)};
`ifdef CORR_SCHED_HEADER_EN
        exp_q.push_back('{16'hFFFF, h[DW-1:0], 1'b0});
`endif
        exp_fc++;
        for (int k = 0; k < NBINS; k++) begin
            r  = RES'(inc_r[k] * nn);
            im = RES'(inc_i[k] * nn);
            exp_q.push_back('{16'(k), {im, r}, (k == NBINS - 1)});
        end
    endtask

    task automatic do_start(input int n, input logic cont);
        integ_cycles = CW'(n);
        continuous   = cont;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        continuous   = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int mode, input string tag);
        int cyc;
        cyc = 0;
        while (got.size() < target && cyc < 400) begin
            if (mode == 1)      m_ready = ~m_ready;
            else if (mode == 2) m_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check({tag, "_beats"}, 64'(got.size()), 64'(target));
    endtask

    task automatic cmp_frame(input int base, input string tag);
        beat_t b;
        for (int i = 0; i < exp_q.size(); i++) begin
            b = (base + i < got.size()) ? got[base + i] : '1;
            check({tag, "_idx"},  64'(b.idx),  64'(exp_q[i].idx));
            check({tag, "_data"}, 64'(b.data), 64'(exp_q[i].data));
            check({tag, "_last"}, 64'(b.last), 64'(exp_q[i].last));
        end
    endtask

    initial begin
        int base, n, v0;

        // Reset state
        for (int k = 0; k < NBINS; k++) begin
            inc_r[k] = '0;
            inc_i[k] = '0;
        end
        repeat (3) tick();
        check("rst_enable",  64'(corr_enable), 64'(0));
        check("rst_clear",   64'(corr_clear),  64'(0));
        check("rst_valid",   64'(m_valid),     64'(0));
        check("rst_last",    64'(m_last),      64'(0));
        check("rst_data",    64'(m_data),      64'(0));
        check("rst_index",   64'(m_index),     64'(0));
        check("rst_busy",    64'(busy),        64'(0));
        check("rst_overrun", 64'(overrun),     64'(0));
        check("rst_dropped", 64'(dropped),     64'(0));
        rst_n = 1'b1;
        tick();

        // Directed single run, N=4, unit increments, cycle-exact timing
        for (int k = 0; k < NBINS; k++) begin
            inc_r[k] = 24'd1;
            inc_i[k] = 24'd1;
        end
        m_ready = 1'b1;
        exp_q.delete();
        exp_fc = 0;
        add_frame(4);
        base = got.size();
        do_start(4, 1'b0);
        check("t1_clear_hi",  64'(corr_clear),  64'(1));
        check("t1_enable_lo", 64'(corr_enable), 64'(0));
        check("t1_busy",      64'(busy),        64'(1));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_integrate_en", 64'(corr_enable), 64'(1));
        end
        tick();
        check("t1_snap_en",    64'(corr_enable), 64'(0));
        check("t1_snap_valid", 64'(m_valid),     64'(0));
        tick();
        check("t1_first_valid", 64'(m_valid),  64'(1));
        check("t1_first_index", 64'(m_index),  64'(exp_q[0].idx));
        wait_beats(base + exp_q.size(), 0, "t1");
        cmp_frame(base, "t1");
        tick();
        check("t1_busy_after",  64'(busy),    64'(0));
        check("t1_valid_after", 64'(m_valid), 64'(0));

        // Zero-length window behaves as N=1
        rand_incs();
        exp_q.delete();
        exp_fc = 0;
        add_frame(0);
        base = got.size();
        do_start(0, 1'b0);
        tick();
        tick();
        check("n0_valid_early", 64'(m_valid), 64'(0));
        tick();
        check("n0_valid_on_time", 64'(m_valid), 64'(1));
        wait_beats(base + exp_q.size(), 0, "n0");
        cmp_frame(base, "n0");

        // Back-pressure: toggled then random ready, random data and window
        for (int pass = 0; pass < 3; pass++) begin
            rand_incs();
            n = $urandom_range(4, 9);
            exp_q.delete();
            exp_fc = 0;
            add_frame(n);
            base = got.size();
            m_ready = 1'b1;
            do_start(n, 1'b0);
            wait_beats(base + exp_q.size(), (pass == 0) ? 1 : 2, "stall");
            cmp_frame(base, "stall");
            m_ready = 1'b1;
            tick();
            tick();
            check("stall_busy_after", 64'(busy),      64'(0));
            check("stall_hold",       64'(stall_bad), 64'(0));
        end

        // Stop on the third integrate cycle: no frame emitted
        rand_incs();
        base = got.size();
        v0 = valid_cycles;
        do_start(10, 1'b0);
        tick();
        tick();
        tick();
        check("stop_en_before", 64'(corr_enable), 64'(1));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_en_after", 64'(corr_enable), 64'(0));
        check("stop_busy",     64'(busy),        64'(0));
        repeat (20) tick();
        check("stop_no_valid", 64'(valid_cycles), 64'(v0));
        check("stop_no_beats", 64'(got.size()),   64'(base));

        // Continuous N=1 with the sink stalled: 9 snapshots, first kept, 8 dropped
        rand_incs();
        m_ready = 1'b0;
        exp_q.delete();
        exp_fc = 0;
        add_frame(1);
        base = got.size();
        do_start(1, 1'b1);
        repeat (19) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("ovr_enable", 64'(corr_enable), 64'(0));
        check("ovr_flag",   64'(overrun),     64'(1));
        check("ovr_count",  64'(dropped),     64'(8));
        check("ovr_valid",  64'(m_valid),     64'(1));
        m_ready = 1'b1;
        wait_beats(base + exp_q.size(), 0, "ovr");
        cmp_frame(base, "ovr");
        tick();
        check("ovr_sticky",     64'(overrun), 64'(1));
        check("ovr_busy_after", 64'(busy),    64'(0));
        check("ovr_hold",       64'(stall_bad), 64'(0));

        // Two continuous frames with a stray start that must be ignored
        rand_incs();
        n = $urandom_range(5, 9);
        m_ready = 1'b1;
        exp_q.delete();
        exp_fc = 0;
        add_frame(n);
        add_frame(n);
        base = got.size();
        do_start(n, 1'b1);
        tick();
        tick();
        integ_cycles = CW'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2 * n) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_beats(base + exp_q.size(), 0, "cont");
        cmp_frame(base, "cont");
        repeat (10) tick();
        check("cont_no_extra", 64'(got.size()), 64'(base + exp_q.size()));
        check("cont_overrun",  64'(overrun),    64'(0));
        check("cont_dropped",  64'(dropped),    64'(0));

        // Asynchronous reset mid-drain, then a fresh frame
        rand_incs();
        m_ready = 1'b0;
        do_start(2, 1'b1);
        repeat (11) tick();
        check("rmid_overrun_pre", 64'(overrun),     64'(1));
        check("rmid_enable_pre",  64'(corr_enable), 64'(1));
        check("rmid_valid_pre",   64'(m_valid),     64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid_valid",   64'(m_valid),     64'(0));
        check("rmid_enable",  64'(corr_enable), 64'(0));
        check("rmid_overrun", 64'(overrun),     64'(0));
        check("rmid_dropped", 64'(dropped),     64'(0));
        check("rmid_busy",    64'(busy),        64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rand_incs();
        m_ready = 1'b1;
        exp_q.delete();
        exp_fc = 0;
        add_frame(5);
        base = got.size();
        do_start(5, 1'b0);
        wait_beats(base + exp_q.size(), 0, "fresh");
        cmp_frame(base, "fresh");
        check("fresh_overrun", 64'(overrun), 64'(0));
        check("fresh_dropped", 64'(dropped), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
